// File: rtl/serial_xor_reduce_pkg.sv
// Shared types and default sizing for the serial XOR reduction block.
package serial_xor_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 16;
  localparam int STEP_DEFAULT  = 4;

endpackage

// File: rtl/serial_xor_reduce_mux.sv
// Plain 2:1 multiplexer; the only primitive the reduction datapath is built from.
module mux (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/serial_xor_reduce.sv
// Serial XOR reduction: folds STEP bits per cycle into an accumulator.
// Build option: define SERIAL_XOR_ODD_PARITY_EN to output the odd-parity bit.
module serial_xor_reduce
  import serial_xor_reduce_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int STEP  = STEP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [STEP:0]    chain;
  logic             parity_raw;

  // Each fold stage is an XOR made of two muxes: an inverter (const 1/0) and a select.
  assign chain[0] = acc_q;

  for (genvar i = 0; i < STEP; i++) begin : g_fold
    logic inv;
    mux u_inv (.d0(1'b1),     .d1(1'b0), .sel(chain[i]),   .y(inv));
    mux u_xor (.d0(chain[i]), .d1(inv),  .sel(shift_q[i]), .y(chain[i+1]));
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        shift_d = shift_q >> STEP;
        acc_d   = chain[STEP];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

`ifdef SERIAL_XOR_ODD_PARITY_EN
  mux u_odd (.d0(1'b1), .d1(1'b0), .sel(acc_q), .y(parity_raw));
`else
  assign parity_raw = acc_q;
`endif

  // Gate with out_valid so the output reads 0 outside DONE in both builds.
  mux u_gate (.d0(1'b0), .d1(parity_raw), .sel(out_valid), .y(out_parity));

endmodule

// File: tb/tb_serial_xor_reduce.sv
// Self-checking bench for serial_xor_reduce: table vectors, corner sequences, STEP sweep.
// Honours SERIAL_XOR_ODD_PARITY_EN when computing expected parity.
module tb_serial_xor_reduce;

   localparam int NDUT = 4;
   localparam int STEPS [NDUT] = '{4, 1, 2, 16};

`ifdef SERIAL_XOR_ODD_PARITY_EN
   localparam bit ODD = 1'b1;
`else
   localparam bit ODD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic [NDUT-1:0] inValid;
   logic [NDUT-1:0] inReady;
   logic [NDUT-1:0] outValid;
   logic [NDUT-1:0] outReady;
   logic [NDUT-1:0] outParity;
   logic [15:0] inData [NDUT];

   int errorCount = 0;
   int checkCount = 0;
   int cycleCount = 0;
   int acceptCycle = 0;
   bit expQ[$];

   typedef struct {
      logic [15:0] word;
      bit          parity;
      int          hold;
      bit          noise;
   } vec_t;

   vec_t tbl [10];

   // One DUT per STEP value, all sharing clock and reset
   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      serial_xor_reduce #(.WIDTH(16), .STEP(STEPS[k])) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (inValid[k]),
         .in_ready  (inReady[k]),
         .in_data   (inData[k]),
         .out_valid (outValid[k]),
         .out_ready (outReady[k]),
         .out_parity(outParity[k])
      );
   end

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycleCount);
      end
   endtask

   // Waits for in_ready, presents one word for one accept edge and queues its expected parity
   task automatic applyStimulus(input int k, input logic [15:0] word, input bit expParity);
      int waitCount = 0;
      @(negedge clk);
      while (!inReady[k] && waitCount < 50) begin
         @(negedge clk);
         waitCount++;
      end
      compare("accept_ready", 32'(inReady[k]), 32'd1);
      inValid[k] = 1'b1;
      inData[k]  = word;
      expQ.push_back(expParity);
      @(posedge clk);
      #1;
      acceptCycle = cycleCount;
      inValid[k] = 1'b0;
   endtask

   // Called just after the accept edge; that edge is counted as edge 1 of the latency
   task automatic checkOutput(input int k, input int holdCycles, input bit noise);
      int n = 16 / STEPS[k];
      int edges = 1;
      bit expP = 1'b0;
      while (!outValid[k] && edges < 100) begin
         if (noise) begin
            inValid[k] = 1'b1;
            inData[k]  = 16'($urandom);
         end
         @(posedge clk);
         #1;
         edges++;
      end
      compare("latency", 32'(edges), 32'(n + 1));
      if (expQ.size() == 0) begin
         compare("queue_nonempty", 32'd0, 32'd1);
      end else begin
         expP = expQ.pop_front();
      end
      compare("parity", 32'(outParity[k]), 32'(expP));
      if (holdCycles > 0) begin
         for (int h = 0; h < holdCycles; h++) begin
            if (noise) begin
               inValid[k] = 1'($urandom_range(0, 1));
               inData[k]  = 16'($urandom);
            end
            @(posedge clk);
            #1;
            compare("hold_valid", 32'(outValid[k]), 32'd1);
            compare("hold_parity", 32'(outParity[k]), 32'(expP));
         end
         inValid[k]  = 1'b0;
         outReady[k] = 1'b1;
      end else begin
         inValid[k] = 1'b0;
      end
      @(posedge clk);
      #1;
      compare("idle_valid", 32'(outValid[k]), 32'd0);
      compare("idle_ready", 32'(inReady[k]), 32'd1);
   endtask

   initial begin
      logic [15:0] w;
      int firstAccept;

      tbl[0] = '{16'h0001, 1'b1, 0, 1'b0};
      tbl[1] = '{16'h0000, 1'b0, 0, 1'b0};
      tbl[2] = '{16'h8000, 1'b1, 0, 1'b1};
      tbl[3] = '{16'h1234, 1'b1, 3, 1'b1};
      tbl[4] = '{16'h7FFF, 1'b1, 3, 1'b0};
      tbl[5] = '{16'hC3C3, 1'b0, 1, 1'b1};
      tbl[6] = '{16'h0F0E, 1'b1, 0, 1'b0};
      tbl[7] = '{16'hDEAD, 1'b1, 2, 1'b1};
      tbl[8] = '{16'hFFFF, 1'b0, 3, 1'b1};
      tbl[9] = '{16'hA5A4, 1'b1, 0, 1'b0};

      inValid  = '0;
      outReady = '1;
      for (int k = 0; k < NDUT; k++) inData[k] = '0;
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         compare("reset_in_ready", 32'(inReady[k]), 32'd1);
         compare("reset_out_valid", 32'(outValid[k]), 32'd0);
         compare("reset_out_parity", 32'(outParity[k]), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Table vectors on the STEP=4 instance
      for (int i = 0; i < 10; i++) begin
         outReady[0] = (tbl[i].hold == 0);
         applyStimulus(0, tbl[i].word, tbl[i].parity ^ ODD);
         checkOutput(0, tbl[i].hold, tbl[i].noise);
      end

      // Back-to-back words with the consumer always ready
      outReady[0] = 1'b1;
      applyStimulus(0, 16'hFFFF, 1'b0 ^ ODD);
      firstAccept = acceptCycle;
      checkOutput(0, 0, 1'b0);
      applyStimulus(0, 16'hA5A4, 1'b1 ^ ODD);
      compare("b2b_gap", 32'(acceptCycle - firstAccept), 32'd6);
      checkOutput(0, 0, 1'b0);

      // Abort in the second BUSY cycle, then accept on the first edge after release
      applyStimulus(0, 16'h0001, 1'b1 ^ ODD);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      compare("abort_out_valid", 32'(outValid[0]), 32'd0);
      compare("abort_in_ready", 32'(inReady[0]), 32'd1);
      compare("abort_out_parity", 32'(outParity[0]), 32'd0);
      expQ.delete();
      inValid[0] = 1'b1;
      inData[0]  = 16'h0003;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expQ.push_back(1'b0 ^ ODD);
      @(posedge clk);
      #1;
      compare("first_accept", 32'(inReady[0]), 32'd0);
      inValid[0] = 1'b0;
      checkOutput(0, 0, 1'b0);

      // Random sweep on the STEP=1, 2 and 16 instances
      for (int k = 1; k < NDUT; k++) begin
         outReady[k] = 1'b1;
         for (int j = 0; j < 1000; j++) begin
            w = 16'($urandom);
            applyStimulus(k, w, (^w) ^ ODD);
            checkOutput(k, 0, 1'b0);
         end
      end

      compare("queue_drained", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
